io_cycle_sequencer: RTL and testbench

//  Sequences the external I/O bus cycle for IN r,(C) / OUT (C),r after the opcode decoder fires.
//  - Start strobes: a start_in or start_out pulse, driven from the PC_I0 / PC_O0 phase of the opcode decoder.
//  - Per-cycle outputs: address (BC), iorq_n, rd_n and wr_n.
//  - Wait handling: inserts automatic wait states and extends the cycle on wait_n, with a timeout abort.
//  - XPT stall: holds the T-state counter with a stall output.
//  - Bus grant: arbitrates the external bus against busreq_n, granting only between cycles.

---
 rtl/io_bus_pkg.sv | 32 +++
 rtl/io_wait_counter.sv | 45 ++++
 rtl/io_cycle_sequencer.sv | 170 +++++++++++++++++
 tb/tb_io_cycle_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared definitions for the I/O bus cycle sequencer: state encoding,
// auto-wait range handling and the default data returned on an aborted IN.
package io_bus_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_T1   = 3'd1;
   localparam logic [2:0] ST_T2   = 3'd2;
   localparam logic [2:0] ST_TW   = 3'd3;
   localparam logic [2:0] ST_T3   = 3'd4;
   localparam logic [2:0] ST_HOLD = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_T1   = ST_T1,
      S_T2   = ST_T2,
      S_TW   = ST_TW,
      S_T3   = ST_T3,
      S_HOLD = ST_HOLD
   } io_state_t;

   localparam int         AUTO_WAITS_MIN = 1;
   localparam int         AUTO_WAITS_MAX = 3;
   localparam logic [7:0] TMO_DATA_DEF   = 8'hFF;

   // Out-of-range auto-wait settings are pinned to the nearest legal value.
   function automatic int clamp_auto_waits(input int n);
      if (n < AUTO_WAITS_MIN) return AUTO_WAITS_MIN;
      if (n > AUTO_WAITS_MAX) return AUTO_WAITS_MAX;
      return n;
   endfunction

endpackage

// File: rtl/io_wait_counter.sv
// Wait-state timing: a loadable auto-wait down-counter plus a saturating
// counter of extra wait cycles used for the timeout abort.
module io_wait_counter
   import io_bus_pkg::*;
#(
   parameter int AUTO_WAITS   = 1,
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic dec,
   input  logic ext,
   output logic zero,
   output logic expired
);

   localparam int              AW    = clamp_auto_waits(AUTO_WAITS);
   localparam int              EW    = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
   localparam logic [1:0]      AW_LD = 2'(AW);
   localparam logic [EW-1:0]   LIMIT = EW'(WAIT_TIMEOUT);

   logic [1:0]    cnt;
   logic [EW-1:0] extra;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         extra <= '0;
      end else if (load) begin
         cnt   <= AW_LD;
         extra <= '0;
      end else begin
         if (dec && cnt != 2'd0)
            cnt <= cnt - 2'd1;
         if (ext && !expired && WAIT_TIMEOUT != 0)
            extra <= extra + EW'(1);
      end
   end

   // zero marks the last automatic wait cycle; it stays set while extending.
   assign zero    = (cnt <= 2'd1);
   assign expired = (WAIT_TIMEOUT != 0) && (extra == LIMIT);

endmodule

// File: rtl/io_cycle_sequencer.sv
// IN r,(C) / OUT (C),r external bus cycle sequencer with wait states,
// timeout abort, XPT stall and between-cycle bus grant.
//
//  state  | meaning
//  IDLE   | no cycle; accepts a start or grants the bus
//  T1     | address driven, strobes idle
//  T2     | iorq_n and rd_n/wr_n asserted, wait counter loaded
//  TW     | automatic and wait_n-extended wait states
//  T3     | strobes held, IN data captured on exit
//  HOLD   | bus granted to external master; one start may be parked
module io_cycle_sequencer
   import io_bus_pkg::*;
#(
   parameter int         AUTO_WAITS   = 1,
   parameter int         WAIT_TIMEOUT = 255,
   parameter logic [7:0] TMO_DATA     = TMO_DATA_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_in,
   input  logic        start_out,
   input  logic [15:0] addr_bc,
   input  logic [7:0]  data_wr,
   output logic [7:0]  io_data_rd,
   output logic        done,
   output logic        stall,
   output logic        timeout,
   output logic        proto_err,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_dout,
   input  logic [7:0]  bus_din,
   output logic        iorq_n,
   output logic        rd_n,
   output logic        wr_n,
   input  logic        wait_n,
   input  logic        busreq_n,
   output logic        busack_n
);

   io_state_t   state, state_nx;
   logic        start, accept, busy_err, set_tmo, pend_valid;
   logic        wc_load, wc_dec, wc_ext, wc_zero, wc_expired;
   logic        cyc_in;
   logic [15:0] cyc_addr;
   logic [7:0]  cyc_data;

   assign start = start_in | start_out;

   io_wait_counter #(
      .AUTO_WAITS   (AUTO_WAITS),
      .WAIT_TIMEOUT (WAIT_TIMEOUT)
   ) u_wait (
      .clk     (clk),
      .reset   (reset),
      .load    (wc_load),
      .dec     (wc_dec),
      .ext     (wc_ext),
      .zero    (wc_zero),
      .expired (wc_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         pend_valid <= 1'b0;
         cyc_in     <= 1'b0;
         cyc_addr   <= '0;
         cyc_data   <= '0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         proto_err  <= 1'b0;
         io_data_rd <= '0;
      end else begin
         state      <= state_nx;
         done       <= (state == S_T3);
         proto_err  <= busy_err | (start_in & start_out);
         pend_valid <= (state == S_HOLD) & (pend_valid | accept) & ~busreq_n;
         if (accept) begin
            cyc_in   <= start_in;
            cyc_addr <= addr_bc;
            cyc_data <= data_wr;
            timeout  <= 1'b0;
         end else if (set_tmo) begin
            timeout  <= 1'b1;
         end
         // timeout is only ever set during this cycle, so it flags the abort here
         if (state == S_T3 && cyc_in)
            io_data_rd <= timeout ? TMO_DATA : bus_din;
      end
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      busy_err = 1'b0;
      set_tmo  = 1'b0;
      wc_load  = 1'b0;
      wc_dec   = 1'b0;
      wc_ext   = 1'b0;
      bus_addr = '0;
      bus_dout = '0;
      iorq_n   = 1'b1;
      rd_n     = 1'b1;
      wr_n     = 1'b1;
      busack_n = 1'b1;
      stall    = 1'b0;
      if (state == S_T2 || state == S_TW || state == S_T3) begin
         iorq_n   = 1'b0;
         rd_n     = ~cyc_in;
         wr_n     = cyc_in;
         bus_dout = cyc_in ? 8'h00 : cyc_data;
      end
      case (state)
         S_IDLE: begin
            stall = start;
            if (start) begin
               accept   = 1'b1;
               state_nx = S_T1;
            end else if (!busreq_n) begin
               state_nx = S_HOLD;
            end
         end
         S_T1: begin
            busy_err = start;
            bus_addr = cyc_addr;
            stall    = 1'b1;
            state_nx = S_T2;
         end
         S_T2: begin
            busy_err = start;
            bus_addr = cyc_addr;
            stall    = 1'b1;
            wc_load  = 1'b1;
            state_nx = S_TW;
         end
         S_TW: begin
            busy_err = start;
            bus_addr = cyc_addr;
            stall    = 1'b1;
            wc_dec   = 1'b1;
            if (wc_zero) begin
               if (wait_n) begin
                  state_nx = S_T3;
               end else if (wc_expired) begin
                  set_tmo  = 1'b1;
                  state_nx = S_T3;
               end else begin
                  wc_ext   = 1'b1;
               end
            end
         end
         S_T3: begin
            busy_err = start;
            bus_addr = cyc_addr;
            stall    = 1'b1;
            state_nx = pend_valid ? S_T1 : S_IDLE;
         end
         S_HOLD: begin
            busack_n = 1'b0;
            busy_err = start & pend_valid;
            accept   = start & ~pend_valid;
            stall    = start | pend_valid;
            if (busreq_n)
               state_nx = (pend_valid | accept) ? S_T1 : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_io_cycle_sequencer.sv
// Randomized bench for io_cycle_sequencer against a cycle-offset reference model.
module tb_io_cycle_sequencer;

   localparam int         AW  = 1;
   localparam int         WT  = 4;
   localparam logic [7:0] TMO = 8'hFF;

   logic        clk = 1'b0;
   logic        reset, start_in, start_out, wait_n, busreq_n;
   logic [15:0] addr_bc, bus_addr;
   logic [7:0]  data_wr, bus_din, io_data_rd, bus_dout;
   logic        done, stall, timeout, proto_err, iorq_n, rd_n, wr_n, busack_n;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  m_rd;
   logic        m_to;

   always #5 clk = ~clk;

   io_cycle_sequencer #(
      .AUTO_WAITS   (AW),
      .WAIT_TIMEOUT (WT),
      .TMO_DATA     (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start_in   (start_in),
      .start_out  (start_out),
      .addr_bc    (addr_bc),
      .data_wr    (data_wr),
      .io_data_rd (io_data_rd),
      .done       (done),
      .stall      (stall),
      .timeout    (timeout),
      .proto_err  (proto_err),
      .bus_addr   (bus_addr),
      .bus_dout   (bus_dout),
      .bus_din    (bus_din),
      .iorq_n     (iorq_n),
      .rd_n       (rd_n),
      .wr_n       (wr_n),
      .wait_n     (wait_n),
      .busreq_n   (busreq_n),
      .busack_n   (busack_n)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pack(input logic [15:0] a, input logic [7:0] dout,
                                        input logic [7:0] rdd, input logic iq, rn, wn,
                                        ak, st, dn, to, pe);
      return {24'h0, a, dout, rdd, iq, rn, wn, ak, st, dn, to, pe};
   endfunction

   function automatic logic [63:0] observed();
      return pack(bus_addr, bus_dout, io_data_rd, iorq_n, rd_n, wr_n, busack_n,
                  stall, done, timeout, proto_err);
   endfunction

   // Cycle 0 is the cycle the sequence begins in. With no hold the start is
   // driven in cycle 0 and T1 is cycle 1; with a hold, HOLD spans cycles
   // 1..hold_len, the start lands at cycle s and T1 follows the release.
   task automatic run_txn(input string tag, input bit is_in, input bit both,
                          input logic [15:0] a, input logic [7:0] d, input logic [7:0] din,
                          input int k, input int hold_len, input bit with_start,
                          input int s, input int err_off);
      int t1, sc, ntw, t3, dn, last, fw, err_at, kk;
      bit abort, ein, inb, io;
      logic [1:0] r;
      logic [7:0] e_rdd;
      ein   = is_in | both;
      kk    = (k > WT) ? WT : k;
      abort = (k > WT);
      ntw   = AW + kk;
      if (hold_len == 0) begin
         t1 = 1; sc = 0;
      end else if (with_start) begin
         t1 = hold_len + 1; sc = s;
      end else begin
         t1 = 1000; sc = 1000;
      end
      t3   = t1 + 2 + ntw;
      dn   = t3 + 1;
      last = (hold_len > 0 && !with_start) ? hold_len + 1 : dn;
      fw   = t1 + 1 + AW;
      err_at = (err_off < 0 || sc >= 1000) ? -10 : sc + 1 + (err_off % (t3 - sc));
      for (int n = 0; n <= last; n++) begin
         @(posedge clk); #1;
         start_in  = 1'b0;
         start_out = 1'b0;
         addr_bc   = 16'($urandom);
         data_wr   = 8'($urandom);
         bus_din   = 8'($urandom);
         wait_n    = 1'($urandom);
         if (hold_len > 0 && n < hold_len)       busreq_n = 1'b0;
         else if (hold_len > 0 && n == hold_len) busreq_n = 1'b1;
         else if (n == dn || n == last)          busreq_n = 1'b1;
         else                                    busreq_n = 1'($urandom);
         if (n == sc) begin
            start_in  = is_in | both;
            start_out = ~is_in | both;
            addr_bc   = a;
            data_wr   = d;
         end
         if (n == err_at) begin
            r = 2'($urandom_range(1, 3));
            start_in  = r[0];
            start_out = r[1];
         end
         if (n >= fw && n < fw + kk + (abort ? 1 : 0)) wait_n = 1'b0;
         else if (!abort && n == fw + kk)              wait_n = 1'b1;
         if (n == t3) bus_din = din;
         @(negedge clk);
         inb   = (n >= t1 && n <= t3);
         io    = (n >= t1 + 1 && n <= t3);
         e_rdd = (n >= dn && ein) ? (abort ? TMO : din) : m_rd;
         check($sformatf("%s_c%0d", tag, n), observed(),
               pack(inb ? a : 16'h0, (io && !ein) ? d : 8'h0, e_rdd,
                    !io, !(io && ein), !(io && !ein),
                    !(hold_len > 0 && n >= 1 && n <= hold_len),
                    (n >= sc && n <= t3), (n == dn),
                    (n <= sc) ? m_to : (abort && n >= t3),
                    (both && n == sc + 1) || (n == err_at + 1)));
      end
      if (sc < 1000) begin
         if (ein) m_rd = abort ? TMO : din;
         m_to = abort;
      end
   endtask

   task automatic reset_in_tw();
      for (int n = 0; n <= 6; n++) begin
         @(posedge clk); #1;
         start_in  = (n == 0);
         start_out = 1'b0;
         addr_bc   = 16'hC0DE;
         busreq_n  = 1'b1;
         wait_n    = (n >= 3) ? 1'b0 : 1'b1;
         reset     = (n == 4);
         @(negedge clk);
         if (n == 4) check("rst_in_tw", {63'h0, iorq_n}, 64'h0);
         if (n >= 5)
            check($sformatf("rst_after_c%0d", n), observed(),
                  pack(16'h0, 8'h0, 8'h0, 1, 1, 1, 1, 0, 0, 0, 0));
      end
      m_rd = 8'h00;
      m_to = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog no_finish");
      $fatal(1);
   end

   initial begin
      bit         is_in, both, ws;
      int         k, hl, s, eo;
      reset     = 1'b1;
      start_in  = 1'b0;
      start_out = 1'b0;
      addr_bc   = 16'h0;
      data_wr   = 8'h0;
      bus_din   = 8'h0;
      wait_n    = 1'b1;
      busreq_n  = 1'b1;
      m_rd      = 8'h00;
      m_to      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", observed(), pack(16'h0, 8'h0, 8'h0, 1, 1, 1, 1, 0, 0, 0, 0));
      @(posedge clk); #1 reset = 1'b0;

      run_txn("t1_in",    1, 0, 16'h12FE, 8'h00, 8'hA5, 0,  0, 0, 0, -1);
      run_txn("t2_out",   0, 0, 16'h0040, 8'h3C, 8'h00, 2,  0, 0, 0, -1);
      run_txn("t3_tmo",   1, 0, 16'h0001, 8'h00, 8'h77, 10, 0, 0, 0, -1);
      run_txn("t3_clr",   1, 0, 16'h0002, 8'h00, 8'h19, 0,  0, 0, 0, -1);
      run_txn("t4_hold",  0, 0, 16'hBEEF, 8'h5A, 8'h00, 0,  4, 1, 2, -1);
      run_txn("t5_err",   1, 0, 16'h3344, 8'h00, 8'h6B, 0,  0, 0, 0, 1);
      run_txn("t5_both",  0, 1, 16'h5566, 8'h11, 8'hE2, 1,  0, 0, 0, -1);
      run_txn("hold_idle",0, 0, 16'h0000, 8'h00, 8'h00, 0,  3, 0, 0, -1);
      reset_in_tw();

      for (int i = 0; i < 150; i++) begin
         is_in = 1'($urandom);
         both  = ($urandom_range(0, 7) == 0);
         k     = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : 0;
         hl    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
         ws    = (hl == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
         s     = (hl == 0) ? 0 : $urandom_range(1, hl);
         eo    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : -1;
         run_txn($sformatf("rnd%0d", i), is_in, both, 16'($urandom), 8'($urandom),
                 8'($urandom), k, hl, ws, s, eo);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
